alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Command-level controller for the 16-bit ALU/accumulator datapath. Accepts one
//  operation at a time over a valid/ready command port, computes it (single-cycle
//  logic/arith ops, or 16-iteration shift-add multiply), pulses the accumulator
//  load strobe with the result and returns it over a valid/ready result port.
//  Sits between the instruction/control front end and the accumulator register.
// PARAMETERS
//  WIDTH  16  operand/result width; MUL iteration count equals WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      block can accept a command (state IDLE and !rst)
//  cmd_op     in   3      opcode (see BEHAVIOUR)
//  cmd_a      in   WIDTH  operand A
//  cmd_b      in   WIDTH  operand B
//  res_valid  out  1      result present
//  res_ready  in   1      consumer takes result
//  res_data   out  WIDTH  result
//  res_ovf    out  1      carry/borrow/multiply overflow
//  res_err    out  1      illegal opcode
//  acc_en     out  1      one-cycle load strobe to accumulator
//  acc_din    out  WIDTH  accumulator load data (equals res_data)
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state IDLE; res_valid, res_data, res_ovf, res_err,
//    acc_en, acc_din, busy all 0; cmd_ready 0 while rst=1. Aborts any op in flight;
//    no result and no acc_en are produced for it.
//  - States: IDLE -> EXEC (op!=MUL) or MUL (op=MUL) on cmd_valid&cmd_ready;
//    EXEC -> DONE after 1 cycle; MUL -> DONE after WIDTH cycles;
//    DONE -> IDLE on res_valid&res_ready.
//  - Operands and opcode latched at accept; cmd_* ignored in all other cycles.
//  - Opcodes: 000 ADD a+b, ovf=carry out; 001 SUB a-b, ovf=borrow (a<b unsigned);
//    010 AND; 011 OR; 100 XOR; 101 PASS a; ovf=0 for 010-101;
//    110 MUL unsigned, res_data=low WIDTH bits, ovf=1 iff high WIDTH bits nonzero;
//    111 illegal: res_data=0, ovf=0, res_err=1, acc_en NOT pulsed. res_err=0 otherwise.
//  - MUL: shift-add over WIDTH cycles, iteration counter 0..WIDTH-1 examines
//    multiplier bit [count]; 2*WIDTH-bit partial product; DONE after count=WIDTH-1.
//  - Latency (accept edge = cycle 0): non-MUL res_valid and acc_en first high in
//    cycle 2; MUL in cycle WIDTH+1 (17). acc_en high exactly 1 cycle, coincident
//    with res_valid rising; acc_din valid in that cycle.
//  - Result outputs registered; res_data/ovf/err held stable while res_valid=1 and
//    res_ready=0. res_valid drops the cycle after the handshake; cmd_ready rises
//    the same cycle. res_ready ignored when res_valid=0.
//  - Throughput: one non-MUL op per 3 cycles with res_ready held high.
//  - res_data/ovf/err retain last value after handshake until next result.
// TESTING
//  - ADD a=FFFF b=0001 -> res_data=0000 ovf=1 err=0, res_valid+acc_en in cycle 2.
//  - SUB a=0003 b=0005 -> FFFE ovf=1; XOR a=F0F0 b=FF00 -> 0FF0 ovf=0.
//  - MUL 00FF*0003 -> 02FD ovf=0 at cycle 17; MUL 0100*0100 -> 0000 ovf=1; busy=1 cycles 1..17.
//  - Backpressure: res_ready=0 for 5 cycles -> res_data stable, cmd_ready=0, second
//    cmd_valid ignored; acc_en single pulse; result transfers when res_ready=1.
//  - rst=1 in cycle 8 of MUL -> next cycle busy=0, no res_valid/acc_en; then PASS
//    a=1234 -> 1234 in cycle 2.
//  - op=111 a=AAAA b=5555 -> res_data=0000 err=1, acc_en stays 0; next ADD clears err.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command-level controller for the ALU/accumulator datapath.
// Takes one operation per valid/ready command, computes it (single-cycle
// logic/arith, or a WIDTH-iteration shift-add multiply), strobes the
// accumulator load and returns the result on a valid/ready result port.
module alu_op_sequencer #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [2:0]       cmd_op_i,
   input  logic [WIDTH-1:0] cmd_a_i,
   input  logic [WIDTH-1:0] cmd_b_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] res_data_o,
   output logic             res_ovf_o,
   output logic             res_err_o,
   output logic             acc_en_o,
   output logic [WIDTH-1:0] acc_din_o,
   output logic             busy_o
);

   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_PASS = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_ILL  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [PW-1:0]      prod_q;
   logic [PW-1:0]      prod_d;
   logic [PW-1:0]      addend_d;
   logic               res_valid_q;
   logic [WIDTH-1:0]   res_data_q;
   logic               res_ovf_q;
   logic               res_err_q;
   logic               acc_en_q;
   logic               busy_q;

   logic [WIDTH:0]     sum_w;
   logic [WIDTH:0]     diff_w;
   logic [WIDTH-1:0]   alu_res_d;
   logic               alu_ovf_d;
   logic               alu_err_d;
   logic               mul_last_w;

   // Accept only when idle and not being reset
   assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;

   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_ovf_o   = res_ovf_q;
   assign res_err_o   = res_err_q;
   assign acc_en_o    = acc_en_q;
   assign acc_din_o   = res_data_q;
   assign busy_o      = busy_q;

   // Carry and borrow come out of the extra top bit
   assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
   assign diff_w = {1'b0, a_q} - {1'b0, b_q};

   // Single-cycle ALU result from the latched operands
   always_comb begin
      alu_res_d = '0;
      alu_ovf_d = 1'b0;
      alu_err_d = 1'b0;
      case (op_q)
         OP_ADD:  begin alu_res_d = sum_w[WIDTH-1:0];  alu_ovf_d = sum_w[WIDTH];  end
         OP_SUB:  begin alu_res_d = diff_w[WIDTH-1:0]; alu_ovf_d = diff_w[WIDTH]; end
         OP_AND:  alu_res_d = a_q & b_q;
         OP_OR:   alu_res_d = a_q | b_q;
         OP_XOR:  alu_res_d = a_q ^ b_q;
         OP_PASS: alu_res_d = a_q;
         OP_ILL:  alu_err_d = 1'b1;
         default: alu_res_d = '0;
      endcase
   end

   // One shift-add step: add the shifted multiplicand when multiplier bit [cnt] is set
   always_comb begin
      addend_d   = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;
      prod_d     = prod_q + addend_d;
      mul_last_w = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // Control FSM with registered result/strobe outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         prod_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_ovf_q   <= 1'b0;
         res_err_q   <= 1'b0;
         acc_en_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  op_q    <= cmd_op_i;
                  a_q     <= cmd_a_i;
                  b_q     <= cmd_b_i;
                  cnt_q   <= '0;
                  prod_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (cmd_op_i == OP_MUL) ? S_MUL : S_EXEC;
               end
            end
            S_EXEC: begin
               res_valid_q <= 1'b1;
               res_data_q  <= alu_res_d;
               res_ovf_q   <= alu_ovf_d;
               res_err_q   <= alu_err_d;
               acc_en_q    <= !alu_err_d;
               state_q     <= S_DONE;
            end
            S_MUL: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (mul_last_w) begin
                  res_valid_q <= 1'b1;
                  res_data_q  <= prod_d[WIDTH-1:0];
                  res_ovf_q   <= |prod_d[PW-1:WIDTH];
                  res_err_q   <= 1'b0;
                  acc_en_q    <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               acc_en_q <= 1'b0;
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
